// File: rtl/dma_bypass_regfile.sv
// dma_bypass_regfile
//   Control/status register file behind a BRAM-style slave port. Control
//   registers are read/write with byte enables. Status registers are read-only
//   live inputs. Reads have a fixed two-cycle latency and are flagged with
//   bram_rdvalid_a. Per-register strobes report control updates and status
//   samples. Accesses to unmapped indices raise access_err.
//
// Ports
//   user_clk, user_aresetn          clock, asynchronous active-low reset
//   bram_en_a / bram_we_a           access request / byte write enables (0 = read)
//   bram_addr_a / bram_wrdata_a     byte address / write data
//   bram_rddata_a / bram_rdvalid_a  read response (held) / one-cycle valid
//   ctrl_reg, ctrl_wr_pulse         control contents (flat, reg i at [i*DATA_W +: DATA_W]) / update strobes
//   stat_reg, stat_rd_pulse         status inputs (flat) / sample strobes (read-to-clear hook)
//   access_err                      one-cycle pulse on unmapped or read-only write access
module dma_bypass_regfile #(
   parameter int                DATA_W    = 512,
   parameter int                N_CTRL    = 32,
   parameter int                N_STAT    = 32,
   parameter int                ADDR_W    = 16,
   parameter int                ADDR_LSB  = 6,
   parameter logic [DATA_W-1:0] CTRL_INIT = '0
) (
   input  logic                     user_clk,
   input  logic                     user_aresetn,
   input  logic                     bram_en_a,
   input  logic [DATA_W/8-1:0]      bram_we_a,
   input  logic [ADDR_W-1:0]        bram_addr_a,
   input  logic [DATA_W-1:0]        bram_wrdata_a,
   output logic [DATA_W-1:0]        bram_rddata_a,
   output logic                     bram_rdvalid_a,
   output logic [N_CTRL*DATA_W-1:0] ctrl_reg,
   output logic [N_CTRL-1:0]        ctrl_wr_pulse,
   input  logic [N_STAT*DATA_W-1:0] stat_reg,
   output logic [N_STAT-1:0]        stat_rd_pulse,
   output logic                     access_err
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(N_CTRL + N_STAT);
   // One extra bit so that N_CTRL+N_STAT is representable when it is a power of two.
   localparam logic [IDX_W:0] CTRL_END = (IDX_W+1)'(N_CTRL);
   localparam logic [IDX_W:0] STAT_END = (IDX_W+1)'(N_CTRL + N_STAT);

   logic [DATA_W-1:0] ctrl_q [N_CTRL];

   logic [IDX_W:0]    idx;
   logic              wr_req;
   logic              rd_req;
   logic              is_ctrl;
   logic [N_CTRL-1:0] ctrl_hit;

   logic              rd_vld1;
   logic [IDX_W:0]    rd_idx1;
   logic [DATA_W-1:0] rd_data_nxt;
   logic [N_STAT-1:0] stat_hit_nxt;
   logic              rd_unmapped1;

   // Address bits above the index field and the byte offset are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^bram_addr_a;

   assign idx     = {1'b0, bram_addr_a[ADDR_LSB +: IDX_W]};
   assign wr_req  = bram_en_a && (|bram_we_a);
   assign rd_req  = bram_en_a && !(|bram_we_a);
   assign is_ctrl = (idx < CTRL_END);

   always_comb begin
      ctrl_hit = '0;
      for (int i = 0; i < N_CTRL; i++) begin
         ctrl_hit[i] = wr_req && (idx == (IDX_W+1)'(i));
      end
   end

   // Stage-2 read mux. The status value is sampled here, one cycle after issue.
   always_comb begin
      rd_data_nxt  = '0;
      stat_hit_nxt = '0;
      rd_unmapped1 = (rd_idx1 >= STAT_END);
      for (int i = 0; i < N_CTRL; i++) begin
         if (rd_idx1 == (IDX_W+1)'(i)) rd_data_nxt = ctrl_q[i];
      end
      for (int j = 0; j < N_STAT; j++) begin
         if (rd_idx1 == (IDX_W+1)'(N_CTRL + j)) begin
            rd_data_nxt     = stat_reg[j*DATA_W +: DATA_W];
            stat_hit_nxt[j] = 1'b1;
         end
      end
   end

   always_ff @(posedge user_clk or negedge user_aresetn) begin
      if (!user_aresetn) begin
         for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= CTRL_INIT;
         ctrl_wr_pulse  <= '0;
      end else begin
         for (int i = 0; i < N_CTRL; i++) begin
            for (int k = 0; k < NB; k++) begin
               if (ctrl_hit[i] && bram_we_a[k])
                  ctrl_q[i][k*8 +: 8] <= bram_wrdata_a[k*8 +: 8];
            end
         end
         ctrl_wr_pulse <= ctrl_hit;
      end
   end

   always_ff @(posedge user_clk or negedge user_aresetn) begin
      if (!user_aresetn) begin
         rd_vld1        <= 1'b0;
         rd_idx1        <= '0;
         bram_rdvalid_a <= 1'b0;
         bram_rddata_a  <= '0;
         stat_rd_pulse  <= '0;
         access_err     <= 1'b0;
      end else begin
         rd_vld1 <= rd_req;
         if (rd_req) rd_idx1 <= idx;
         bram_rdvalid_a <= rd_vld1;
         if (rd_vld1) bram_rddata_a <= rd_data_nxt;
         stat_rd_pulse <= rd_vld1 ? stat_hit_nxt : '0;
         // A bad write issued one cycle after a bad read lands in the same cycle; both raise the flag.
         access_err <= (wr_req && !is_ctrl) || (rd_vld1 && rd_unmapped1);
      end
   end

   for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_out
      assign ctrl_reg[g*DATA_W +: DATA_W] = ctrl_q[g];
   end

endmodule
